// File: rtl/tetris_pkg.sv
// Shared playfield geometry, colour-index type and piece palette for the
// tile renderer and the next-piece preview.
package tetris_pkg;

  localparam int CELL_PX    = 24;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COL0 = 7;

  localparam logic [11:0] BG_RGB_DEFAULT = 12'h112;
  localparam logic [11:0] GRID_RGB       = 12'h333;

  typedef logic [2:0] color_idx_t;

  // Piece colours, indexed 1..7 in the order I, O, T, S, Z, J, L.
  localparam logic [11:0] PAL_I = 12'h0FF;
  localparam logic [11:0] PAL_O = 12'hFF0;
  localparam logic [11:0] PAL_T = 12'hA0F;
  localparam logic [11:0] PAL_S = 12'h0F0;
  localparam logic [11:0] PAL_Z = 12'hF00;
  localparam logic [11:0] PAL_J = 12'h00F;
  localparam logic [11:0] PAL_L = 12'hF80;

  function automatic logic [11:0] bevel_rgb(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/tile_palette.sv
// Combinational colour-index to RGB lookup; bevel halves each channel.
// Also used by the next-piece preview.
module tile_palette
  import tetris_pkg::*;
(
  input  color_idx_t  idx,
  input  logic        bevel,
  output logic [11:0] rgb
);

  logic [11:0] base;

  always_comb begin
    case (idx)
      3'd1:    base = PAL_I;
      3'd2:    base = PAL_O;
      3'd3:    base = PAL_T;
      3'd4:    base = PAL_S;
      3'd5:    base = PAL_Z;
      3'd6:    base = PAL_J;
      3'd7:    base = PAL_L;
      default: base = 12'h000;
    endcase
    rgb = bevel ? bevel_rgb(base) : base;
  end

endmodule

// File: rtl/tile_pixel_pipe.sv
// Three-stage block-coordinate to RGB pipeline with matching sync delay.
// Define TILE_GRID_EN to draw grid lines on the edges of empty cells.
module tile_pixel_pipe
  import tetris_pkg::*;
#(
  parameter logic [11:0] BG_RGB = BG_RGB_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  h_blkid,
  input  logic [5:0]  h_offset,
  input  logic [4:0]  v_blkid,
  input  logic [5:0]  v_offset,
  input  logic        in_active,
  input  logic        in_hsync,
  input  logic        in_vsync,
  output logic        cell_rd_en,
  output logic [7:0]  cell_addr,
  input  logic [2:0]  cell_data,
  output logic [11:0] rgb,
  output logic        out_active,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        frame_tick
);

  logic        in_board, in_edge;
  logic [7:0]  addr_next;

  logic        s0_board, s0_edge, s0_active, s0_hsync, s0_vsync;
  color_idx_t  s1_idx;
  logic        s1_board, s1_edge, s1_active, s1_hsync, s1_vsync;
  logic [11:0] pal_rgb, rgb_next;

  always_comb begin
    in_board  = in_active
             && (h_blkid >= 5'(BOARD_COL0))
             && (h_blkid <= 5'(BOARD_COL0 + BOARD_COLS - 1))
             && (v_blkid <  5'(BOARD_ROWS));
    in_edge   = (h_offset == 6'd0) || (h_offset == 6'(CELL_PX - 1))
             || (v_offset == 6'd0) || (v_offset == 6'(CELL_PX - 1));
    addr_next = 8'(v_blkid) * 8'(BOARD_COLS) + 8'(h_blkid) - 8'(BOARD_COL0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_rd_en <= 1'b0;
      cell_addr  <= 8'd0;
      s0_board   <= 1'b0;
      s0_edge    <= 1'b0;
      s0_active  <= 1'b0;
      s0_hsync   <= 1'b1;
      s0_vsync   <= 1'b1;
    end else begin
      cell_rd_en <= in_board;
      if (in_board)
        cell_addr <= addr_next;
      s0_board   <= in_board;
      s0_edge    <= in_edge;
      s0_active  <= in_active;
      s0_hsync   <= in_hsync;
      s0_vsync   <= in_vsync;
    end
  end

  // Off-board reads are never issued, so whatever the bus carries is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_idx    <= '0;
      s1_board  <= 1'b0;
      s1_edge   <= 1'b0;
      s1_active <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
    end else begin
      s1_idx    <= s0_board ? cell_data : 3'd0;
      s1_board  <= s0_board;
      s1_edge   <= s0_edge;
      s1_active <= s0_active;
      s1_hsync  <= s0_hsync;
      s1_vsync  <= s0_vsync;
    end
  end

  tile_palette u_palette (
    .idx   (s1_idx),
    .bevel (s1_edge),
    .rgb   (pal_rgb)
  );

  always_comb begin
    rgb_next = 12'h000;
    if (!s1_active)
      rgb_next = 12'h000;
    else if (!s1_board)
      rgb_next = BG_RGB;
    else if (s1_idx == 3'd0) begin
`ifdef TILE_GRID_EN
      rgb_next = s1_edge ? GRID_RGB : 12'h000;
`else
      rgb_next = 12'h000;
`endif
    end else
      rgb_next = pal_rgb;
  end

  // out_vsync doubles as the vsync edge register, so frame_tick lines up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb        <= 12'h000;
      out_active <= 1'b0;
      out_hsync  <= 1'b1;
      out_vsync  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= rgb_next;
      out_active <= s1_active;
      out_hsync  <= s1_hsync;
      out_vsync  <= s1_vsync;
      frame_tick <= out_vsync & ~s1_vsync;
    end
  end

endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Directed self-checking bench for tile_pixel_pipe with a behavioural board RAM.
module tb_tile_pixel_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  h_blkid;
  logic [5:0]  h_offset;
  logic [4:0]  v_blkid;
  logic [5:0]  v_offset;
  logic        in_active, in_hsync, in_vsync;
  logic        cell_rd_en;
  logic [7:0]  cell_addr;
  logic [2:0]  cell_data;
  logic [11:0] rgb;
  logic        out_active, out_hsync, out_vsync, frame_tick;

  logic [2:0]  ram [0:255];
  int          checks   = 0;
  int          failures = 0;

`ifdef TILE_GRID_EN
  localparam logic [11:0] GRID_EXP = 12'h333;
`else
  localparam logic [11:0] GRID_EXP = 12'h000;
`endif

  always #5 clk = ~clk;

  assign cell_data = cell_rd_en ? ram[cell_addr] : 3'd0;

  tile_pixel_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .h_blkid    (h_blkid),
    .h_offset   (h_offset),
    .v_blkid    (v_blkid),
    .v_offset   (v_offset),
    .in_active  (in_active),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .cell_rd_en (cell_rd_en),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .rgb        (rgb),
    .out_active (out_active),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int h, input int ho, input int v, input int vo, input logic act);
    h_blkid   = 5'(h);
    h_offset  = 6'(ho);
    v_blkid   = 5'(v);
    v_offset  = 6'(vo);
    in_active = act;
  endtask

  task automatic idle();
    set_px(0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 3'd0;
    ram[0]   = 3'd3;
    ram[199] = 3'd5;
    ram[22]  = 3'd7;
    reset    = 1'b1;
    in_hsync = 1'b1;
    in_vsync = 1'b1;
    idle();

    #2;
    check("rst_rgb",     32'(rgb), 32'h000);
    check("rst_hsync",   32'(out_hsync), 32'd1);
    check("rst_vsync",   32'(out_vsync), 32'd1);
    check("rst_rd_en",   32'(cell_rd_en), 32'd0);
    check("rst_addr",    32'(cell_addr), 32'd0);
    check("rst_tick",    32'(frame_tick), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("idle_rgb",    32'(rgb), 32'h000);
    check("idle_active", 32'(out_active), 32'd0);
    check("idle_hsync",  32'(out_hsync), 32'd1);
    check("idle_vsync",  32'(out_vsync), 32'd1);
    check("idle_tick",   32'(frame_tick), 32'd0);

    // first board cell, interior pixel, T piece
    set_px(7, 5, 0, 5, 1'b1);
    tick();
    check("a_rd_en", 32'(cell_rd_en), 32'd1);
    check("a_addr",  32'(cell_addr), 32'd0);
    idle();
    tick();
    check("a_rgb_early", 32'(rgb), 32'h000);
    tick();
    check("a_rgb",    32'(rgb), 32'hA0F);
    check("a_active", 32'(out_active), 32'd1);
    tick();
    check("inactive_rgb",    32'(rgb), 32'h000);
    check("inactive_active", 32'(out_active), 32'd0);

    // last board cell, left edge pixel, bevelled Z piece
    set_px(16, 0, 19, 5, 1'b1);
    tick();
    check("b_rd_en", 32'(cell_rd_en), 32'd1);
    check("b_addr",  32'(cell_addr), 32'd199);
    idle();
    tick();
    tick();
    check("b_rgb", 32'(rgb), 32'h700);

    set_px(17, 5, 5, 5, 1'b1);
    tick();
    check("c_rd_en", 32'(cell_rd_en), 32'd0);
    check("c_addr_hold", 32'(cell_addr), 32'd199);
    idle();
    tick();
    tick();
    check("c_rgb",    32'(rgb), 32'h112);
    check("c_active", 32'(out_active), 32'd1);

    set_px(6, 5, 5, 5, 1'b1);
    tick();
    check("h6_rd_en", 32'(cell_rd_en), 32'd0);
    idle();
    tick();
    tick();
    check("h6_rgb", 32'(rgb), 32'h112);

    set_px(8, 5, 20, 5, 1'b1);
    tick();
    check("v20_rd_en", 32'(cell_rd_en), 32'd0);
    idle();
    tick();
    tick();
    check("v20_rgb", 32'(rgb), 32'h112);

    // empty cell on its bottom edge: grid colour only when grid is built in
    set_px(8, 5, 3, 23, 1'b1);
    tick();
    check("g_rd_en", 32'(cell_rd_en), 32'd1);
    check("g_addr",  32'(cell_addr), 32'd31);
    idle();
    tick();
    tick();
    check("g_rgb", 32'(rgb), 32'(GRID_EXP));

    set_px(8, 5, 3, 5, 1'b1);
    tick();
    idle();
    tick();
    tick();
    check("empty_rgb", 32'(rgb), 32'h000);

    set_px(9, 5, 2, 23, 1'b1);
    tick();
    check("l_addr", 32'(cell_addr), 32'd22);
    idle();
    tick();
    tick();
    check("l_rgb", 32'(rgb), 32'h740);

    // vsync falling edge and frame_tick alignment
    in_vsync = 1'b0;
    tick();
    tick();
    check("vs_n2_vsync", 32'(out_vsync), 32'd1);
    check("vs_n2_tick",  32'(frame_tick), 32'd0);
    tick();
    check("vs_n3_vsync", 32'(out_vsync), 32'd0);
    check("vs_n3_tick",  32'(frame_tick), 32'd1);
    tick();
    check("vs_n4_vsync", 32'(out_vsync), 32'd0);
    check("vs_n4_tick",  32'(frame_tick), 32'd0);
    in_vsync = 1'b1;
    tick();
    tick();
    tick();
    check("vs_rise_vsync", 32'(out_vsync), 32'd1);
    check("vs_rise_tick",  32'(frame_tick), 32'd0);

    // asynchronous reset in the middle of a line
    in_hsync = 1'b0;
    set_px(7, 5, 0, 5, 1'b1);
    tick();
    tick();
    tick();
    check("pre_rst_rgb",   32'(rgb), 32'hA0F);
    check("pre_rst_hsync", 32'(out_hsync), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rgb",   32'(rgb), 32'h000);
    check("async_hsync", 32'(out_hsync), 32'd1);
    check("async_rd_en", 32'(cell_rd_en), 32'd0);
    in_hsync = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("realign_early", 32'(rgb), 32'h000);
    tick();
    check("realign_rgb", 32'(rgb), 32'hA0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_pixel_pipe.md
Name: tile_pixel_pipe

Overview:
- Downstream consumer of the horizontal block-id/offset mapper and its vertical counterpart.
- Turns per-pixel (block column, block row, intra-block offsets) into a board-cell read, then into an RGB pixel.
- Delays VGA sync/active by the pipeline depth so pixels stay aligned.
- Sits between the pixel-to-block mappers and the VGA output pins.

Parameters:
- CELL_PX, 24, cell edge in pixels; offsets range 0..CELL_PX-1.
- BOARD_COLS, 10, playfield width in cells.
- BOARD_ROWS, 20, playfield height in cells.
- BOARD_COL0, 7, first block column of the playfield. Board spans pixels 168..407.
- BG_RGB, 12'h112, colour outside the playfield.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- h_blkid  in  5  block column 0..23
- h_offset  in  6  pixel offset in column, 0..23
- v_blkid  in  5  block row 0..19
- v_offset  in  6  pixel offset in row, 0..23
- in_active  in  1  visible-area flag
- in_hsync  in  1  hsync, active-low
- in_vsync  in  1  vsync, active-low
- cell_rd_en  out  1  board RAM read strobe
- cell_addr  out  8  v_blkid*BOARD_COLS + (h_blkid-BOARD_COL0)
- cell_data  in  3  colour index; 0 = empty; valid 1 cycle after cell_rd_en
- rgb  out  12  4:4:4 pixel
- out_active  out  1  in_active delayed 3
- out_hsync  out  1  in_hsync delayed 3
- out_vsync  out  1  in_vsync delayed 3
- frame_tick  out  1  one-cycle pulse on a registered in_vsync falling edge

Behaviour:
- Reset (async, high) forces these values. Held until the first clk edge after deassertion.
  - rgb=0, out_active=0, cell_rd_en=0, cell_addr=0, frame_tick=0.
  - out_hsync=1, out_vsync=1 (inactive).
  - All pipeline registers and the vsync edge register also reset; the vsync edge register resets to 1.
- Stage S0 (cycle 1): register inputs.
  - in_board = in_active && h_blkid in [BOARD_COL0, BOARD_COL0+BOARD_COLS-1] && v_blkid < BOARD_ROWS.
  - cell_rd_en = in_board. cell_addr computed in 8 bits; held at its previous value when !in_board.
  - Carry forward: in_board, edge flag (offset==0 or offset==CELL_PX-1 on either axis), active, syncs.
- Stage S1 (cycle 2): cell_data is valid. Register it, forcing the captured value to 0 when in_board=0.
- Stage S2 (cycle 3): colour selection, registered to rgb.
  - !active: 0.
  - !in_board: BG_RGB.
  - in_board, cell empty: 12'h000.
  - in_board, cell nonzero: palette[idx], or palette[idx]>>1 per channel when the edge flag is set (bevel).
- Latency is exactly 3 clk from inputs to rgb/out_*. It is fixed: no stalls, no handshake; the pipeline advances every cycle.
- frame_tick goes high in the cycle out_vsync goes 1→0. It is computed from the delayed vsync, so it aligns with the output.
- Boundaries:
  - h_blkid=6 or 17 → outside board, no read.
  - h_blkid=7/v_blkid=0 → addr 0.
  - h_blkid=16/v_blkid=19 → addr 199.
  - Offsets ≥ CELL_PX are illegal input; behaviour is unspecified but must not produce X on outputs.
- Reset mid-line: pipeline contents are discarded; syncs go inactive immediately. Output realigns 3 cycles after release.

Optional Feature:
- Macro TILE_GRID_EN.
- Defined: empty in-board pixels with the edge flag set output 12'h333 (grid lines); all other pixels unchanged.
- Undefined: empty cells are solid 12'h000 and no grid logic is synthesised.

Decomposition:
- Shared package tetris_pkg holds:
  - CELL_PX, BOARD_COLS, BOARD_ROWS, BOARD_COL0.
  - color_idx_t (3-bit) typedef.
  - 7-entry palette constants (I cyan, O yellow, T purple, S green, Z red, J blue, L orange).
- One combinational sub-module, tile_palette: takes idx and the bevel flag, returns 12-bit RGB. It is reused by the next-piece preview.

Test Plan:
- Reset release with in_hsync=in_vsync=1 → outputs hold reset values.
- Assert reset at an arbitrary cycle → rgb=0 and syncs=1 asynchronously, before the next clk edge.
- h_blkid=7, h_offset=5, v_blkid=0, v_offset=5, active; RAM returns 3 → cell_rd_en=1 and cell_addr=0 in cycle 1; rgb=palette[3] in cycle 3.
- h_blkid=16, v_blkid=19, h_offset=0; RAM returns 5 → addr=199; rgb=palette[5]>>1 (bevel).
- h_blkid=17, active → cell_rd_en=0; rgb=BG_RGB after 3 cycles.
- in_active=0 → rgb=0.
- Toggle in_vsync 1→0 at cycle N → out_vsync falls at N+3; frame_tick=1 for exactly cycle N+3.
- With TILE_GRID_EN: empty cell, v_offset=23 → rgb=12'h333.
- Without TILE_GRID_EN: same stimulus → rgb=12'h000.
